// File: rtl/ddr_pixel_stream_tx.sv
// AXI-Stream master that reads one lattice frame out of the direction BRAMs
// and streams it as one 144-bit beat per pixel, tlast on the final pixel.
module ddr_pixel_stream_tx #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 2500,
  parameter int ADDRESS_WIDTH = 12,
  parameter int READ_LATENCY  = 1
) (
  input  logic                       m00_axis_aclk,
  input  logic                       m00_axis_aresetn,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       rd_en,
  output logic [ADDRESS_WIDTH-1:0]   rd_addr,
  input  logic [DATA_WIDTH-1:0]      n_in,
  input  logic [DATA_WIDTH-1:0]      null_in,
  input  logic [DATA_WIDTH-1:0]      ne_in,
  input  logic [DATA_WIDTH-1:0]      e_in,
  input  logic [DATA_WIDTH-1:0]      se_in,
  input  logic [DATA_WIDTH-1:0]      s_in,
  input  logic [DATA_WIDTH-1:0]      sw_in,
  input  logic [DATA_WIDTH-1:0]      w_in,
  input  logic [DATA_WIDTH-1:0]      nw_in,
  output logic                       m00_axis_tvalid,
  output logic [9*DATA_WIDTH-1:0]    m00_axis_tdata,
  output logic [9*DATA_WIDTH/8-1:0]  m00_axis_tstrb,
  output logic                       m00_axis_tlast,
  input  logic                       m00_axis_tready
);

  localparam int TDATA_WIDTH = 9 * DATA_WIDTH;

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SEND, DONE} state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                     rd_en_q, rd_en_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tlast_q, tlast_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [1:0]               lat_q, lat_d;
  logic [TDATA_WIDTH-1:0]   tdata_q, tdata_d;
  logic [TDATA_WIDTH-1:0]   pixel;

  // Lane order mirrors the pixel-in unpacker so a round trip is address-exact.
  assign pixel = {nw_in, w_in, sw_in, s_in, se_in, e_in, ne_in, null_in, n_in};

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    rd_en_d   = 1'b0;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    done_d    = 1'b0;
    lat_d     = lat_q;
    tdata_d   = tdata_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = ADDR;
          rd_addr_d = '0;
          rd_en_d   = 1'b1;
        end
      end
      ADDR: begin
        lat_d   = 2'd0;
        state_d = WAIT;
      end
      WAIT: begin
        lat_d = lat_q + 2'd1;
        if (lat_q == 2'(READ_LATENCY - 1)) begin
          tdata_d  = pixel;
          tlast_d  = (rd_addr_q == ADDRESS_WIDTH'(DEPTH - 1));
          tvalid_d = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (m00_axis_tready) begin
          tvalid_d = 1'b0;
          if (tlast_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            rd_addr_d = rd_addr_q + ADDRESS_WIDTH'(1);
            rd_en_d   = 1'b1;
            state_d   = ADDR;
          end
        end
      end
      DONE: begin
        tvalid_d  = 1'b0;
        tlast_d   = 1'b0;
        rd_addr_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q   <= IDLE;
      rd_addr_q <= '0;
      rd_en_q   <= 1'b0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      lat_q     <= 2'd0;
      tdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      rd_en_q   <= rd_en_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      lat_q     <= lat_d;
      tdata_q   <= tdata_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tlast  = tlast_q;
  assign m00_axis_tstrb  = '1;

endmodule

// File: tb/tb_ddr_pixel_stream_tx.sv
// Bench for ddr_pixel_stream_tx: startup vector table, scoreboarded full frames
// under random backpressure, mid-frame reset, plus small-DEPTH / long-latency instances.
module tb_ddr_pixel_stream_tx;

  logic         clk = 1'b0;
  logic         aresetn;
  logic         start, tready;
  logic         busy, done, rd_en, tvalid, tlast;
  logic [11:0]  rd_addr;
  logic [143:0] tdata;
  logic [17:0]  tstrb;
  logic [11:0]  ba1 = '0;

  logic         start_s, tready_s;
  logic         busy2, done2, rd_en2, tvalid2, tlast2;
  logic [11:0]  rd_addr2;
  logic [143:0] tdata2;
  logic [17:0]  tstrb2;
  logic [11:0]  a2_1 = '0, a2_2 = '0, a2_3 = '0;
  logic         busy3, done3, rd_en3, tvalid3, tlast3;
  logic [11:0]  rd_addr3;
  logic [143:0] tdata3;
  logic [17:0]  tstrb3;
  logic [11:0]  ba3 = '0;

  int checks = 0;
  int errors = 0;
  int exp_pix = 0, beats = 0, tlast_cnt = 0, done_cnt = 0, ncyc = 0, last_acc = 0;
  bit tight_mode = 0;

  always #5 clk = ~clk;

  // BRAM content: lane k of pixel a is {a, k}
  function automatic logic [15:0] lane(input logic [11:0] a, input int k);
    return {a, 4'(k)};
  endfunction

  function automatic logic [143:0] pack(input int pix);
    logic [143:0] r;
    for (int k = 0; k < 9; k++) r[k*16 +: 16] = lane(12'(pix), k);
    return r;
  endfunction

  always @(posedge clk) if (rd_en) ba1 <= rd_addr;
  always @(posedge clk) begin
    if (rd_en2) a2_1 <= rd_addr2;
    a2_2 <= a2_1;
    a2_3 <= a2_2;
  end
  always @(posedge clk) if (rd_en3) ba3 <= rd_addr3;

  ddr_pixel_stream_tx #(.DATA_WIDTH(16), .DEPTH(2500), .ADDRESS_WIDTH(12), .READ_LATENCY(1)) dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr),
    .n_in(lane(ba1, 0)), .null_in(lane(ba1, 1)), .ne_in(lane(ba1, 2)), .e_in(lane(ba1, 3)),
    .se_in(lane(ba1, 4)), .s_in(lane(ba1, 5)), .sw_in(lane(ba1, 6)), .w_in(lane(ba1, 7)),
    .nw_in(lane(ba1, 8)),
    .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
    .m00_axis_tlast(tlast), .m00_axis_tready(tready));

  ddr_pixel_stream_tx #(.DATA_WIDTH(16), .DEPTH(2), .ADDRESS_WIDTH(12), .READ_LATENCY(3)) dut2 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .start(start_s), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_addr(rd_addr2),
    .n_in(lane(a2_3, 0)), .null_in(lane(a2_3, 1)), .ne_in(lane(a2_3, 2)), .e_in(lane(a2_3, 3)),
    .se_in(lane(a2_3, 4)), .s_in(lane(a2_3, 5)), .sw_in(lane(a2_3, 6)), .w_in(lane(a2_3, 7)),
    .nw_in(lane(a2_3, 8)),
    .m00_axis_tvalid(tvalid2), .m00_axis_tdata(tdata2), .m00_axis_tstrb(tstrb2),
    .m00_axis_tlast(tlast2), .m00_axis_tready(tready_s));

  ddr_pixel_stream_tx #(.DATA_WIDTH(16), .DEPTH(1), .ADDRESS_WIDTH(12), .READ_LATENCY(1)) dut3 (
    .m00_axis_aclk(clk), .m00_axis_aresetn(aresetn), .start(start_s), .busy(busy3), .done(done3),
    .rd_en(rd_en3), .rd_addr(rd_addr3),
    .n_in(lane(ba3, 0)), .null_in(lane(ba3, 1)), .ne_in(lane(ba3, 2)), .e_in(lane(ba3, 3)),
    .se_in(lane(ba3, 4)), .s_in(lane(ba3, 5)), .sw_in(lane(ba3, 6)), .w_in(lane(ba3, 7)),
    .nw_in(lane(ba3, 8)),
    .m00_axis_tvalid(tvalid3), .m00_axis_tdata(tdata3), .m00_axis_tstrb(tstrb3),
    .m00_axis_tlast(tlast3), .m00_axis_tready(tready_s));

  task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        start;
    logic        tready;
    logic        busy;
    logic        rd_en;
    logic [11:0] addr;
    logic        tvalid;
    logic        tlast;
    logic        done;
    int          pix;
  } vec_t;

  vec_t tbl[8];

  task automatic applyStimulus(input vec_t v);
    start  = v.start;
    tready = v.tready;
  endtask

  // Scoreboard: every accepted beat must be the next pixel in order, and a
  // stalled beat must hold its payload until accepted.
  initial begin : monitor
    bit           hold_q = 0;
    logic [143:0] hold_data = '0;
    logic         hold_last = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!aresetn) hold_q = 0;
      else begin
        if (hold_q) begin
          checkOutput("hold_tvalid", tvalid, 1);
          checkOutput("hold_tdata", tdata, hold_data);
          checkOutput("hold_tlast", tlast, hold_last);
        end
        if (tvalid && tready) begin
          checkOutput("beat_tdata", tdata, pack(exp_pix));
          checkOutput("beat_tlast", tlast, exp_pix == 2499);
          checkOutput("beat_rd_addr", rd_addr, exp_pix);
          if (tight_mode && beats > 0) checkOutput("beat_spacing", ncyc - last_acc, 3);
          last_acc = ncyc;
          beats++;
          exp_pix++;
          if (tlast) tlast_cnt++;
        end
        if (done) done_cnt++;
        hold_q    = tvalid && !tready;
        hold_data = tdata;
        hold_last = tlast;
      end
    end
  end

  // Runs (or continues) a frame on the main instance until done, optionally
  // injecting ignored starts or aborting with reset at pixel reset_at.
  task automatic run_frame(input bit do_start, input bit tight, input bit inject, input int reset_at);
    bit seen_v = 0;
    bit inj10  = 0;
    bit fin    = 0;
    tight_mode = tight;
    if (do_start) begin
      exp_pix = 0; beats = 0; tlast_cnt = 0; done_cnt = 0;
      start = 1;
    end
    for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start  = 0;
      tready = tight ? 1'b1 : 1'($urandom_range(0, 1));
      if (do_start && !seen_v && tvalid) begin
        seen_v = 1;
        checkOutput("first_tvalid_latency", cyc, 3);
      end
      if (inject && !inj10 && tvalid && rd_addr == 12'd10) begin
        start = 1;
        inj10 = 1;
      end
      if (done) begin
        fin = 1;
        if (inject) start = 1;
      end
      if (reset_at >= 0 && tvalid && rd_addr == 12'(reset_at)) begin
        aresetn = 0;
        #1;
        checkOutput("abort_tvalid", tvalid, 0);
        checkOutput("abort_tlast", tlast, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_rd_addr", rd_addr, 0);
        tready = 0;
        @(negedge clk);
        aresetn = 1;
        @(posedge clk); #1;
        return;
      end
    end
    checkOutput("frame_timeout", fin, 1);
    @(posedge clk); #1;
    start = 0;
    checkOutput("idle_busy", busy, 0);
    checkOutput("idle_done", done, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("start_in_done_ignored", busy, 0);
    checkOutput("frame_beats", beats, 2500);
    checkOutput("frame_tlast_count", tlast_cnt, 1);
    checkOutput("frame_done_count", done_cnt, 1);
  endtask

  initial begin
    int b2 = 0, d2 = 0, b3 = 0, d3 = 0;
    tbl[0] = '{1, 1, 1, 1, 12'd0, 0, 0, 0, -1};
    tbl[1] = '{0, 1, 1, 0, 12'd0, 0, 0, 0, -1};
    tbl[2] = '{0, 0, 1, 0, 12'd0, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 1, 0, 12'd0, 1, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 1, 12'd1, 0, 0, 0, -1};
    tbl[5] = '{0, 0, 1, 0, 12'd1, 0, 0, 0, -1};
    tbl[6] = '{1, 1, 1, 0, 12'd1, 1, 0, 0, 1};
    tbl[7] = '{1, 1, 1, 1, 12'd2, 0, 0, 0, -1};

    aresetn = 0; start = 0; tready = 1; start_s = 0; tready_s = 1;
    #12;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_rd_en", rd_en, 0);
    checkOutput("reset_rd_addr", rd_addr, 0);
    checkOutput("reset_tvalid", tvalid, 0);
    checkOutput("reset_tdata", tdata, 0);
    checkOutput("reset_tlast", tlast, 0);
    checkOutput("tstrb", tstrb, 18'h3ffff);
    @(negedge clk);
    aresetn = 1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      checkOutput($sformatf("vec%0d_rd_en", i), rd_en, tbl[i].rd_en);
      checkOutput($sformatf("vec%0d_rd_addr", i), rd_addr, tbl[i].addr);
      checkOutput($sformatf("vec%0d_tvalid", i), tvalid, tbl[i].tvalid);
      checkOutput($sformatf("vec%0d_tlast", i), tlast, tbl[i].tlast);
      checkOutput($sformatf("vec%0d_done", i), done, tbl[i].done);
      if (tbl[i].pix >= 0) checkOutput($sformatf("vec%0d_tdata", i), tdata, pack(tbl[i].pix));
    end

    run_frame(0, 0, 1, -1);
    run_frame(1, 1, 0, -1);
    run_frame(1, 1, 0, 700);
    run_frame(1, 1, 0, -1);

    // Long-latency two-pixel frame and single-pixel frame side by side.
    start_s = 1; tready_s = 1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(posedge clk); #1;
      start_s = 0;
      if (tvalid2) begin
        checkOutput("dut2_tdata", tdata2, pack(b2));
        checkOutput("dut2_tlast", tlast2, b2 == 1);
        checkOutput("dut2_spacing", cyc, 5 * (b2 + 1));
        b2++;
      end
      if (done2) begin
        checkOutput("dut2_done_cycle", cyc, 11);
        d2++;
      end
      if (tvalid3) begin
        checkOutput("dut3_tdata", tdata3, pack(0));
        checkOutput("dut3_tlast", tlast3, 1);
        checkOutput("dut3_first_tvalid", cyc, 3);
        b3++;
      end
      if (done3) begin
        checkOutput("dut3_done_cycle", cyc, 4);
        d3++;
      end
    end
    checkOutput("dut2_beats", b2, 2);
    checkOutput("dut2_done_count", d2, 1);
    checkOutput("dut2_busy", busy2, 0);
    checkOutput("dut2_tstrb", tstrb2, 18'h3ffff);
    checkOutput("dut3_beats", b3, 1);
    checkOutput("dut3_done_count", d3, 1);
    checkOutput("dut3_busy", busy3, 0);
    checkOutput("dut3_tstrb", tstrb3, 18'h3ffff);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
